// File: rtl/hilihase_pkg.sv
// Shared types for the hilihase drive path: 4-state codes, drive command
// format and scheduler state.
package hilihase_pkg;

    // Widths of the buffered command record; drivers instantiate with
    // ID_W/TIME_W no wider than these.
    localparam int unsigned CMD_ID_W   = 8;
    localparam int unsigned CMD_TIME_W = 32;

    typedef enum logic [1:0] {
        HV_0 = 2'd0,
        HV_1 = 2'd1,
        HV_X = 2'd2,
        HV_Z = 2'd3
    } hv_t;

    typedef struct packed {
        logic [CMD_ID_W-1:0]   id;
        hv_t                   val;
        logic [CMD_TIME_W-1:0] at_time;
    } drive_cmd_t;

    typedef enum logic [1:0] {
        EMPTY,
        WAIT,
        DUE
    } sched_state_t;

endpackage

// File: rtl/hilihase_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head.
module hilihase_cmd_fifo
    import hilihase_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  drive_cmd_t               push_cmd,
    input  logic                     pop,
    output drive_cmd_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned AW = $clog2(DEPTH);

    drive_cmd_t       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign fill    = count;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hilihase_drive_sched.sv
// Time-scheduled signal driver: buffers drive commands and applies each to
// its lane once the stepped harness time reaches the command's time.
module hilihase_drive_sched
    import hilihase_pkg::*;
#(
    parameter int unsigned N_SIG  = 8,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned TIME_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ID_W-1:0]           cmd_id,
    input  logic [1:0]                cmd_val,
    input  logic [TIME_W-1:0]         cmd_time,
    input  logic                      step,
    output logic                      step_ready,
    output logic [TIME_W-1:0]         cur_time,
    output logic [N_SIG-1:0]          sig_out,
    output logic [N_SIG-1:0]          sig_oe,
    output logic [N_SIG-1:0]          sig_x,
    output logic                      err_id,
    output logic                      err_late,
    output logic [$clog2(DEPTH):0]    fill
);

    drive_cmd_t          wr_cmd;
    drive_cmd_t          head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                head_late;
    logic                head_bad_id;
    logic [TIME_W-1:0]   d;
    sched_state_t        state;

    assign wr_cmd = '{id: CMD_ID_W'(cmd_id), val: hv_t'(cmd_val),
                      at_time: CMD_TIME_W'(cmd_time)};

    assign cmd_ready = !fifo_full && !rst;

    hilihase_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid && cmd_ready),
        .push_cmd (wr_cmd),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .fill     (fill)
    );

    // Serial-number distance: the sign bit of the wrapped difference says late.
    assign d           = head.at_time[TIME_W-1:0] - cur_time;
    assign head_late   = d[TIME_W-1];
    assign head_bad_id = (head.id == '0) || (head.id > CMD_ID_W'(N_SIG));

    // State follows the current buffer contents so a due command pops on the
    // edge right after it is accepted.
    always_comb begin
        state = EMPTY;
        if (!fifo_empty) begin
            state = (head_late || (d == '0)) ? DUE : WAIT;
        end
    end

    assign pop        = (state == DUE);
    assign step_ready = (state != DUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_time <= '0;
            sig_out  <= '0;
            sig_oe   <= '0;
            sig_x    <= '0;
            err_id   <= 1'b0;
            err_late <= 1'b0;
        end else begin
            if (step && step_ready) begin
                cur_time <= cur_time + TIME_W'(1);
            end
            err_id   <= pop && head_bad_id;
            err_late <= pop && head_late;
            for (int unsigned i = 0; i < N_SIG; i++) begin
                if (pop && !head_bad_id && (head.id == CMD_ID_W'(i + 1))) begin
                    case (head.val)
                        HV_0: begin sig_out[i] <= 1'b0; sig_oe[i] <= 1'b1; sig_x[i] <= 1'b0; end
                        HV_1: begin sig_out[i] <= 1'b1; sig_oe[i] <= 1'b1; sig_x[i] <= 1'b0; end
                        HV_X: begin sig_out[i] <= 1'b0; sig_oe[i] <= 1'b1; sig_x[i] <= 1'b1; end
                        default: begin sig_out[i] <= 1'b0; sig_oe[i] <= 1'b0; sig_x[i] <= 1'b0; end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_hilihase_drive_sched.sv
// Directed bench for hilihase_drive_sched: default build plus a TIME_W=4
// instance for the time-wrap case.
module tb_hilihase_drive_sched;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, step, step_ready, err_id, err_late;
    logic [7:0]  cmd_id;
    logic [1:0]  cmd_val;
    logic [31:0] cmd_time, cur_time;
    logic [7:0]  sig_out, sig_oe, sig_x;
    logic [3:0]  fill;

    logic        w_valid, w_ready, w_step, w_step_ready, w_err_id, w_err_late;
    logic [7:0]  w_id;
    logic [1:0]  w_val;
    logic [3:0]  w_time, w_cur_time;
    logic [7:0]  w_sig_out, w_sig_oe, w_sig_x;
    logic [3:0]  w_fill;

    logic [7:0]  exp_out, exp_oe, exp_x;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    hilihase_drive_sched #(.N_SIG(8), .ID_W(8), .TIME_W(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_val(cmd_val), .cmd_time(cmd_time),
        .step(step), .step_ready(step_ready), .cur_time(cur_time),
        .sig_out(sig_out), .sig_oe(sig_oe), .sig_x(sig_x),
        .err_id(err_id), .err_late(err_late), .fill(fill)
    );

    hilihase_drive_sched #(.N_SIG(8), .ID_W(8), .TIME_W(4), .DEPTH(8)) dut_w (
        .clk(clk), .rst(rst), .cmd_valid(w_valid), .cmd_ready(w_ready),
        .cmd_id(w_id), .cmd_val(w_val), .cmd_time(w_time),
        .step(w_step), .step_ready(w_step_ready), .cur_time(w_cur_time),
        .sig_out(w_sig_out), .sig_oe(w_sig_oe), .sig_x(w_sig_x),
        .err_id(w_err_id), .err_late(w_err_late), .fill(w_fill)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 0; cmd_id = 0; cmd_val = 0; cmd_time = 0; step = 0;
        w_valid = 0; w_id = 0; w_val = 0; w_time = 0; w_step = 0;
        @(negedge clk);
        cyc();
        cyc();
        n_vec += 8;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready: got %0d expected 0", cmd_ready); end
        if (step_ready !== 1'b1) begin n_bad++; $display("FAIL reset_step_ready: got %0d expected 1", step_ready); end
        if (cur_time !== 32'd0) begin n_bad++; $display("FAIL reset_cur_time: got %0d expected 0", cur_time); end
        if (sig_oe !== 8'h00) begin n_bad++; $display("FAIL reset_sig_oe: got %h expected 00", sig_oe); end
        if (sig_out !== 8'h00 || sig_x !== 8'h00) begin n_bad++; $display("FAIL reset_sig_out_x: got %h/%h expected 00/00", sig_out, sig_x); end
        if (fill !== 4'd0) begin n_bad++; $display("FAIL reset_fill: got %0d expected 0", fill); end
        if (err_id !== 1'b0 || err_late !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0d/%0d expected 0/0", err_id, err_late); end
        if (w_cur_time !== 4'd0) begin n_bad++; $display("FAIL reset_w_cur_time: got %0d expected 0", w_cur_time); end
        rst = 1'b0;
        cyc();
        n_vec++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_cmd_ready: got %0d expected 1", cmd_ready); end
        exp_out = 8'h00; exp_oe = 8'h00; exp_x = 8'h00;
    endtask

    task automatic test_first_cmd();
        cmd_valid = 1; cmd_id = 8'd3; cmd_val = 2'd1; cmd_time = 32'd0;
        cyc();
        cmd_valid = 0;
        n_vec += 3;
        if (fill !== 4'd1) begin n_bad++; $display("FAIL first_fill: got %0d expected 1", fill); end
        if (step_ready !== 1'b0) begin n_bad++; $display("FAIL first_step_ready_due: got %0d expected 0", step_ready); end
        if (sig_oe !== 8'h00) begin n_bad++; $display("FAIL first_not_yet: got %h expected 00", sig_oe); end
        cyc();
        exp_out = 8'h04; exp_oe = 8'h04;
        n_vec += 5;
        if (sig_out !== exp_out) begin n_bad++; $display("FAIL first_sig_out: got %h expected %h", sig_out, exp_out); end
        if (sig_oe !== exp_oe) begin n_bad++; $display("FAIL first_sig_oe: got %h expected %h", sig_oe, exp_oe); end
        if (sig_x !== exp_x) begin n_bad++; $display("FAIL first_sig_x: got %h expected %h", sig_x, exp_x); end
        if (err_id !== 1'b0 || err_late !== 1'b0) begin n_bad++; $display("FAIL first_err: got %0d/%0d expected 0/0", err_id, err_late); end
        if (step_ready !== 1'b1) begin n_bad++; $display("FAIL first_step_ready: got %0d expected 1", step_ready); end
    endtask

    task automatic test_multi_due();
        cmd_valid = 1;
        cmd_id = 8'd1; cmd_val = 2'd3; cmd_time = 32'd5; cyc();
        cmd_id = 8'd2; cmd_val = 2'd2; cmd_time = 32'd5; cyc();
        cmd_id = 8'd1; cmd_val = 2'd0; cmd_time = 32'd5; cyc();
        cmd_valid = 0;
        n_vec += 2;
        if (fill !== 4'd3) begin n_bad++; $display("FAIL multi_fill: got %0d expected 3", fill); end
        if (step_ready !== 1'b1) begin n_bad++; $display("FAIL multi_wait_ready: got %0d expected 1", step_ready); end
        step = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_vec++;
            if (cur_time !== 32'(i + 1)) begin n_bad++; $display("FAIL multi_step: got %0d expected %0d", cur_time, i + 1); end
        end
        n_vec++;
        if (step_ready !== 1'b0) begin n_bad++; $display("FAIL multi_due_ready: got %0d expected 0", step_ready); end
        for (int p = 0; p < 3; p++) begin
            cyc();
            n_vec += 3;
            if (cur_time !== 32'd5) begin n_bad++; $display("FAIL multi_hold_time: got %0d expected 5", cur_time); end
            if (fill !== 4'(2 - p)) begin n_bad++; $display("FAIL multi_pop_fill: got %0d expected %0d", fill, 2 - p); end
            if (step_ready !== (p == 2)) begin n_bad++; $display("FAIL multi_pop_ready: got %0d expected %0d", step_ready, p == 2); end
        end
        exp_oe = 8'h07; exp_x = 8'h02;
        n_vec += 3;
        if (sig_out !== exp_out) begin n_bad++; $display("FAIL multi_sig_out: got %h expected %h", sig_out, exp_out); end
        if (sig_oe !== exp_oe) begin n_bad++; $display("FAIL multi_sig_oe: got %h expected %h", sig_oe, exp_oe); end
        if (sig_x !== exp_x) begin n_bad++; $display("FAIL multi_sig_x: got %h expected %h", sig_x, exp_x); end
        cyc();
        step = 0;
        n_vec++;
        if (cur_time !== 32'd6) begin n_bad++; $display("FAIL multi_step_after: got %0d expected 6", cur_time); end
    endtask

    task automatic test_full();
        logic [1:0] vals [8];
        vals = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1};
        cmd_valid = 1; cmd_id = 8'd6; cmd_time = 32'd100;
        for (int k = 0; k < 8; k++) begin
            cmd_val = vals[k];
            cyc();
        end
        n_vec += 2;
        if (fill !== 4'd8) begin n_bad++; $display("FAIL full_fill: got %0d expected 8", fill); end
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0d expected 0", cmd_ready); end
        cmd_id = 8'd7; cmd_val = 2'd1;
        cyc();
        n_vec++;
        if (fill !== 4'd8) begin n_bad++; $display("FAIL full_held: got %0d expected 8", fill); end
        step = 1;
        for (int s = 0; s < 93; s++) cyc();
        n_vec += 2;
        if (cur_time !== 32'd99) begin n_bad++; $display("FAIL full_time99: got %0d expected 99", cur_time); end
        if (sig_oe !== exp_oe || sig_out !== exp_out) begin n_bad++; $display("FAIL full_early_lane: got %h/%h expected %h/%h", sig_oe, sig_out, exp_oe, exp_out); end
        cyc();
        step = 0;
        n_vec += 4;
        if (cur_time !== 32'd100) begin n_bad++; $display("FAIL full_time100: got %0d expected 100", cur_time); end
        if (step_ready !== 1'b0) begin n_bad++; $display("FAIL full_due_ready: got %0d expected 0", step_ready); end
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_before_pop: got %0d expected 0", cmd_ready); end
        if (sig_oe !== exp_oe) begin n_bad++; $display("FAIL full_no_change: got %h expected %h", sig_oe, exp_oe); end
        cyc();
        n_vec += 3;
        if (fill !== 4'd7) begin n_bad++; $display("FAIL full_pop1_fill: got %0d expected 7", fill); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_rise: got %0d expected 1", cmd_ready); end
        if (sig_oe[5] !== 1'b1 || sig_out[5] !== 1'b0) begin n_bad++; $display("FAIL full_lane5_first: got oe %0d out %0d expected 1/0", sig_oe[5], sig_out[5]); end
        cyc();
        cmd_valid = 0;
        n_vec++;
        if (fill !== 4'd7) begin n_bad++; $display("FAIL full_push_pop_fill: got %0d expected 7", fill); end
        for (int t = 0; t < 12; t++) begin
            if (fill == 4'd0) break;
            cyc();
        end
        exp_out = 8'h64; exp_oe = 8'h67;
        n_vec += 5;
        if (fill !== 4'd0) begin n_bad++; $display("FAIL full_drain: got %0d expected 0", fill); end
        if (sig_out !== exp_out) begin n_bad++; $display("FAIL full_sig_out: got %h expected %h", sig_out, exp_out); end
        if (sig_oe !== exp_oe) begin n_bad++; $display("FAIL full_sig_oe: got %h expected %h", sig_oe, exp_oe); end
        if (sig_x !== exp_x) begin n_bad++; $display("FAIL full_sig_x: got %h expected %h", sig_x, exp_x); end
        if (err_late !== 1'b0) begin n_bad++; $display("FAIL full_err_late: got %0d expected 0", err_late); end
    endtask

    task automatic test_bad_id();
        logic [7:0] ids [2];
        ids = '{8'd0, 8'd9};
        for (int b = 0; b < 2; b++) begin
            cmd_valid = 1; cmd_id = ids[b]; cmd_val = 2'd1; cmd_time = 32'd100;
            cyc();
            cmd_valid = 0;
            n_vec++;
            if (err_id !== 1'b0) begin n_bad++; $display("FAIL badid_pre: got %0d expected 0", err_id); end
            cyc();
            n_vec += 3;
            if (err_id !== 1'b1) begin n_bad++; $display("FAIL badid_pulse id=%0d: got %0d expected 1", ids[b], err_id); end
            if (err_late !== 1'b0) begin n_bad++; $display("FAIL badid_late: got %0d expected 0", err_late); end
            if (sig_out !== exp_out || sig_oe !== exp_oe || sig_x !== exp_x) begin n_bad++; $display("FAIL badid_lanes: got %h/%h/%h expected %h/%h/%h", sig_out, sig_oe, sig_x, exp_out, exp_oe, exp_x); end
            cyc();
            n_vec++;
            if (err_id !== 1'b0) begin n_bad++; $display("FAIL badid_one_cycle: got %0d expected 0", err_id); end
        end
    endtask

    task automatic test_step_and_push();
        step = 1; cmd_valid = 1; cmd_id = 8'd4; cmd_val = 2'd1; cmd_time = 32'd100;
        cyc();
        step = 0; cmd_valid = 0;
        n_vec += 3;
        if (cur_time !== 32'd101) begin n_bad++; $display("FAIL late_step: got %0d expected 101", cur_time); end
        if (step_ready !== 1'b0) begin n_bad++; $display("FAIL late_due: got %0d expected 0", step_ready); end
        if (fill !== 4'd1) begin n_bad++; $display("FAIL late_fill: got %0d expected 1", fill); end
        cyc();
        exp_out = exp_out | 8'h08; exp_oe = exp_oe | 8'h08;
        n_vec += 4;
        if (sig_out !== exp_out || sig_oe !== exp_oe) begin n_bad++; $display("FAIL late_lane3: got %h/%h expected %h/%h", sig_out, sig_oe, exp_out, exp_oe); end
        if (err_late !== 1'b1) begin n_bad++; $display("FAIL late_pulse: got %0d expected 1", err_late); end
        if (err_id !== 1'b0) begin n_bad++; $display("FAIL late_err_id: got %0d expected 0", err_id); end
        if (step_ready !== 1'b1) begin n_bad++; $display("FAIL late_ready: got %0d expected 1", step_ready); end
        cyc();
        n_vec++;
        if (err_late !== 1'b0) begin n_bad++; $display("FAIL late_one_cycle: got %0d expected 0", err_late); end
    endtask

    task automatic test_wrap();
        w_step = 1;
        for (int s = 0; s < 14; s++) cyc();
        w_step = 0;
        n_vec++;
        if (w_cur_time !== 4'd14) begin n_bad++; $display("FAIL wrap_t14: got %0d expected 14", w_cur_time); end
        w_valid = 1; w_id = 8'd2; w_val = 2'd1; w_time = 4'd1;
        cyc();
        w_valid = 0;
        n_vec += 3;
        if (w_fill !== 4'd1) begin n_bad++; $display("FAIL wrap_fill: got %0d expected 1", w_fill); end
        if (w_step_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_not_due14: got %0d expected 1", w_step_ready); end
        if (w_sig_oe !== 8'h00) begin n_bad++; $display("FAIL wrap_no_apply14: got %h expected 00", w_sig_oe); end
        w_step = 1;
        cyc();
        n_vec++;
        if (w_cur_time !== 4'd15 || w_step_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_t15: got %0d/%0d expected 15/1", w_cur_time, w_step_ready); end
        cyc();
        n_vec++;
        if (w_cur_time !== 4'd0 || w_step_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_t0: got %0d/%0d expected 0/1", w_cur_time, w_step_ready); end
        cyc();
        w_step = 0;
        n_vec += 2;
        if (w_cur_time !== 4'd1 || w_step_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_t1_due: got %0d/%0d expected 1/0", w_cur_time, w_step_ready); end
        if (w_sig_oe !== 8'h00) begin n_bad++; $display("FAIL wrap_no_apply_yet: got %h expected 00", w_sig_oe); end
        cyc();
        n_vec += 4;
        if (w_sig_out !== 8'h02 || w_sig_oe !== 8'h02) begin n_bad++; $display("FAIL wrap_apply: got %h/%h expected 02/02", w_sig_out, w_sig_oe); end
        if (w_err_late !== 1'b0 || w_err_id !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %0d/%0d expected 0/0", w_err_late, w_err_id); end
        if (w_step_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready: got %0d expected 1", w_step_ready); end
        if (w_fill !== 4'd0) begin n_bad++; $display("FAIL wrap_fill_end: got %0d expected 0", w_fill); end
    endtask

    initial begin
        test_reset();
        test_first_cmd();
        test_multi_due();
        test_full();
        test_bad_id();
        test_step_and_push();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
